cpu_regfile: RTL and testbench
==============================

# cpu_regfile

Parametrised general-purpose register file for the experimental CPU datapath: 2^ADDR_W registers of DATA_W bits, one write port and two independent registered read ports (A and B operand buses). It replaces the fixed 4×8 single-port file and adds a second read port, synchronous bulk clear, per-register dirty tracking and a flattened debug view for the board display. It sits between the instruction decoder (addresses, strobes) and the ALU operand latches.

## Interface
- DATA_W, 8, register width in bits (≥1)
- ADDR_W, 2, address width; DEPTH = 2^ADDR_W registers (1..5)
- RST_VAL, 0, reset/clear value of every register (DATA_W bits)
- clk  in  1  system clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- wr_n  in  1  active-low write strobe
- wa  in  ADDR_W  write address
- wd  in  DATA_W  write data
- rd_en  in  1  read enable, both ports; when low, read outputs hold
- ra_a  in  ADDR_W  read address, port A
- ra_b  in  ADDR_W  read address, port B
- clr  in  1  synchronous clear of all registers and dirty bits
- rdata_a  out  DATA_W  registered read data, port A
- rdata_b  out  DATA_W  registered read data, port B
- dirty  out  DEPTH  bit i set = register i written since last reset/clear
- dbg_regs  out  DATA_W*DEPTH  all registers flattened, register i at bits [i*DATA_W +: DATA_W]

## Operation
- Reset (rst_n=0, immediate): all registers = RST_VAL, rdata_a = rdata_b = 0, dirty = 0. Reset mid-write discards the write.
- Write: wr_n=0 and clr=0 at a rising edge → reg[wa] <= wd, dirty[wa] <= 1.
- Clear: clr=1 at a rising edge → all registers = RST_VAL, dirty = 0; clr wins over a simultaneous write (write dropped). Read ports still sample in that cycle (see below).
- Read: rd_en=1 at a rising edge → rdata_a <= value(ra_a), rdata_b <= value(ra_b). rd_en=0 → both hold previous values.
- value(x) is the register content before the edge, except as modified by the configuration feature; during clr, value(x) = pre-clear content.
- ra_a = ra_b is legal; both ports return the same data.
- Address arithmetic: addresses are exactly ADDR_W bits, no out-of-range case exists.
- dbg_regs and dirty are direct register views (no extra latency).

## Timing
- Write latency: data visible on dbg_regs 1 cycle after the write edge; visible on rdata_* after the next read edge.
- Read latency: 1 cycle (address at edge N → rdata at edge N output).
- No handshake; one write and two reads may occur every cycle.
- Simultaneous write and read of same address: governed by REGFILE_BYPASS_EN.

## Configuration
- REGFILE_BYPASS_EN defined: if wr_n=0, clr=0, rd_en=1 and ra_x = wa at the same edge, rdata_x <= wd (write-through bypass, new data).
- Not defined: rdata_x <= old register content (read-before-write).
- All other behaviour identical in both builds.

## Structure
- Shared package cpu_pkg: default DATA_W/ADDR_W constants, RST_VAL default, regfile address type.
- One sub-module: regfile_rdport (address mux + optional bypass + output register), instantiated twice for ports A and B.
- Storage array, write decode, clear and dirty logic live in cpu_regfile.

## Test plan
- Reset: drive rst_n=0 mid-cycle with wr_n=0 → registers, rdata_a/b, dirty all 0 immediately; write lost.
- Write/read all: write 8'h11,8'h22,8'h33,8'h44 to R0..R3, then ra_a=1, ra_b=3, rd_en=1 → next edge rdata_a=8'h22, rdata_b=8'h44, dirty=4'b1111.
- Same-address collision: R2=8'h33, write 8'hAA to R2 with ra_a=2, rd_en=1 → rdata_a=8'hAA with REGFILE_BYPASS_EN, 8'h33 without; R2=8'hAA afterwards in both.
- Read hold: rd_en=0 while changing ra_a/ra_b and writing → rdata_a/b unchanged.
- Clear vs write: clr=1 with wr_n=0, wa=1, wd=8'h5A, ra_a=1 → R1=0, dirty=0, rdata_a = pre-clear R1.
- Parameter sweep: DATA_W=16, ADDR_W=3 → write 16'hBEEF to R7, read on port B → 16'hBEEF, dirty=8'h80, dbg_regs[127:112]=16'hBEEF.

Source files
------------

// File: rtl/cpu_regfile_pkg.sv
// Shared CPU datapath constants and types for the register file slice.
package cpu_pkg;

  localparam int unsigned CPU_DATA_W = 8;
  localparam int unsigned CPU_ADDR_W = 2;
  localparam logic [CPU_DATA_W-1:0] CPU_RST_VAL = '0;

  typedef logic [CPU_ADDR_W-1:0] reg_addr_t;

endpackage

// File: rtl/cpu_regfile_if.sv
// Decoder-to-register-file bus: write strobe/address/data, two read ports, debug views.
interface cpu_regfile_if
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_W = CPU_DATA_W,
  parameter int unsigned ADDR_W = CPU_ADDR_W
);
  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic                      wr_n;
  logic [ADDR_W-1:0]         wa;
  logic [DATA_W-1:0]         wd;
  logic                      rd_en;
  logic [ADDR_W-1:0]         ra_a;
  logic [ADDR_W-1:0]         ra_b;
  logic                      clr;
  logic [DATA_W-1:0]         rdata_a;
  logic [DATA_W-1:0]         rdata_b;
  logic [DEPTH-1:0]          dirty;
  logic [DATA_W*DEPTH-1:0]   dbg_regs;

  modport master (
    output wr_n, wa, wd, rd_en, ra_a, ra_b, clr,
    input  rdata_a, rdata_b, dirty, dbg_regs
  );

  modport slave (
    input  wr_n, wa, wd, rd_en, ra_a, ra_b, clr,
    output rdata_a, rdata_b, dirty, dbg_regs
  );

endinterface

// File: rtl/cpu_regfile_rdport.sv
// One registered read port: address mux over the flattened file, output register.
// REGFILE_BYPASS_EN selects write-through of same-edge write data; otherwise read-before-write.
module regfile_rdport
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_W = CPU_DATA_W,
  parameter int unsigned ADDR_W = CPU_ADDR_W,
  parameter int unsigned DEPTH  = 1 << ADDR_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_rd_en,
  input  logic [ADDR_W-1:0]       i_ra,
  input  logic [DATA_W*DEPTH-1:0] i_regs,
  input  logic                    i_wr_en,
  input  logic [ADDR_W-1:0]       i_wa,
  input  logic [DATA_W-1:0]       i_wd,
  output logic [DATA_W-1:0]       o_rdata
);

  logic [DATA_W-1:0] w_sel;
  logic [DATA_W-1:0] r_rdata;

  always_comb begin
    w_sel = i_regs[i_ra*DATA_W +: DATA_W];
`ifdef REGFILE_BYPASS_EN
    if (i_wr_en && (i_ra == i_wa)) w_sel = i_wd;
`endif
  end

`ifndef REGFILE_BYPASS_EN
  logic w_unused_bypass;
  assign w_unused_bypass = ^{i_wr_en, i_wa, i_wd};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata <= '0;
    end else if (i_rd_en) begin
      r_rdata <= w_sel;
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/cpu_regfile.sv
// Parametrised register file: one write port, two registered read ports, bulk clear,
// dirty tracking and flattened debug view. Optional macro: REGFILE_BYPASS_EN.
module cpu_regfile
  import cpu_pkg::*;
#(
  parameter int unsigned       DATA_W  = CPU_DATA_W,
  parameter int unsigned       ADDR_W  = CPU_ADDR_W,
  parameter logic [DATA_W-1:0] RST_VAL = DATA_W'(CPU_RST_VAL)
) (
  input logic          clk,
  input logic          rst_n,
  cpu_regfile_if.slave bus
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0]       r_mem [DEPTH];
  logic [DEPTH-1:0]        r_dirty;
  logic [DATA_W*DEPTH-1:0] w_regs;
  logic                    w_wr_en;

  // Clear outranks a simultaneous write; the read ports still see pre-edge contents.
  assign w_wr_en = !bus.wr_n && !bus.clr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem   <= '{default: RST_VAL};
      r_dirty <= '0;
    end else if (bus.clr) begin
      r_mem   <= '{default: RST_VAL};
      r_dirty <= '0;
    end else if (w_wr_en) begin
      r_mem[bus.wa]   <= bus.wd;
      r_dirty[bus.wa] <= 1'b1;
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_flat
    assign w_regs[g*DATA_W +: DATA_W] = r_mem[g];
  end

  assign bus.dirty    = r_dirty;
  assign bus.dbg_regs = w_regs;

  regfile_rdport #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_rd_a (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_rd_en (bus.rd_en),
    .i_ra    (bus.ra_a),
    .i_regs  (w_regs),
    .i_wr_en (w_wr_en),
    .i_wa    (bus.wa),
    .i_wd    (bus.wd),
    .o_rdata (bus.rdata_a)
  );

  regfile_rdport #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_rd_b (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_rd_en (bus.rd_en),
    .i_ra    (bus.ra_b),
    .i_regs  (w_regs),
    .i_wr_en (w_wr_en),
    .i_wa    (bus.wa),
    .i_wd    (bus.wd),
    .o_rdata (bus.rdata_b)
  );

endmodule

// File: tb/tb_cpu_regfile.sv
// Scoreboard bench for cpu_regfile: default 8x4 instance plus a 16x8 instance,
// array-based reference model, expectations queued by the driver and popped by a monitor.
module tb_cpu_regfile;
  import cpu_pkg::*;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cpu_regfile_if #(.DATA_W(8),  .ADDR_W(2)) bs ();
  cpu_regfile_if #(.DATA_W(16), .ADDR_W(3)) bw ();

  cpu_regfile #(.DATA_W(8), .ADDR_W(2), .RST_VAL(8'h00)) dut_s (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bs)
  );

  cpu_regfile #(.DATA_W(16), .ADDR_W(3), .RST_VAL(16'h0000)) dut_w (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bw)
  );

  typedef struct {
    int           sel;
    logic [15:0]  ra;
    logic [15:0]  rb;
    logic [7:0]   dirty;
    logic [127:0] dbg;
  } exp_t;

  exp_t q[$];
  int n_err = 0;
  int n_checks = 0;

  logic [15:0] m_mem [2][8];
  logic [7:0]  m_dirty [2];
  logic [15:0] m_ra [2];
  logic [15:0] m_rb [2];

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 8; i++) m_mem[s][i] = '0;
      m_dirty[s] = '0;
      m_ra[s] = '0;
      m_rb[s] = '0;
    end
  endtask

  task automatic idle_s();
    bs.wr_n = 1'b1; bs.wa = '0; bs.wd = '0; bs.rd_en = 1'b0;
    bs.ra_a = '0; bs.ra_b = '0; bs.clr = 1'b0;
  endtask

  task automatic idle_w();
    bw.wr_n = 1'b1; bw.wa = '0; bw.wd = '0; bw.rd_en = 1'b0;
    bw.ra_a = '0; bw.ra_b = '0; bw.clr = 1'b0;
  endtask

  // One clock of stimulus on the selected instance; the expected post-edge view is queued.
  task automatic drive(input int sel, input bit wr, input int wa, input logic [15:0] wd,
                       input bit rd, input int ra, input int rb, input bit clr);
    int dw;
    int depth;
    logic [15:0] wdm;
    logic [15:0] na;
    logic [15:0] nb;
    exp_t e;
    dw    = (sel != 0) ? 16 : 8;
    depth = (sel != 0) ? 8 : 4;
    wdm   = (sel != 0) ? wd : {8'h00, wd[7:0]};
    @(negedge clk);
    if (sel == 0) begin
      bs.wr_n = !wr; bs.wa = 2'(wa); bs.wd = wd[7:0]; bs.rd_en = rd;
      bs.ra_a = 2'(ra); bs.ra_b = 2'(rb); bs.clr = clr;
      idle_w();
    end else begin
      bw.wr_n = !wr; bw.wa = 3'(wa); bw.wd = wd; bw.rd_en = rd;
      bw.ra_a = 3'(ra); bw.ra_b = 3'(rb); bw.clr = clr;
      idle_s();
    end
    na = m_ra[sel];
    nb = m_rb[sel];
    if (rd) begin
      na = (BYP && wr && !clr && ra == wa) ? wdm : m_mem[sel][ra];
      nb = (BYP && wr && !clr && rb == wa) ? wdm : m_mem[sel][rb];
    end
    m_ra[sel] = na;
    m_rb[sel] = nb;
    if (clr) begin
      for (int i = 0; i < 8; i++) m_mem[sel][i] = '0;
      m_dirty[sel] = '0;
    end else if (wr) begin
      m_mem[sel][wa] = wdm;
      m_dirty[sel][wa] = 1'b1;
    end
    e.sel = sel;
    e.ra = na;
    e.rb = nb;
    e.dirty = m_dirty[sel];
    e.dbg = '0;
    for (int i = 0; i < depth; i++) e.dbg |= 128'(m_mem[sel][i]) << (i * dw);
    q.push_back(e);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_s_rdata_a"}, 128'(bs.rdata_a), '0);
    chk({tag, "_s_rdata_b"}, 128'(bs.rdata_b), '0);
    chk({tag, "_s_dirty"},   128'(bs.dirty),   '0);
    chk({tag, "_s_dbg"},     128'(bs.dbg_regs), '0);
    chk({tag, "_w_rdata_a"}, 128'(bw.rdata_a), '0);
    chk({tag, "_w_dirty"},   128'(bw.dirty),   '0);
    chk({tag, "_w_dbg"},     128'(bw.dbg_regs), '0);
  endtask

  // Monitor: compares the DUT view shortly after every edge for which an expectation exists.
  initial begin
    exp_t e;
    logic [15:0]  ga, gb;
    logic [7:0]   gd;
    logic [127:0] gg;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        if (e.sel == 0) begin
          ga = 16'(bs.rdata_a); gb = 16'(bs.rdata_b);
          gd = 8'(bs.dirty);    gg = 128'(bs.dbg_regs);
        end else begin
          ga = bw.rdata_a; gb = bw.rdata_b;
          gd = bw.dirty;   gg = 128'(bw.dbg_regs);
        end
        chk("rdata_a",  128'(ga), 128'(e.ra));
        chk("rdata_b",  128'(gb), 128'(e.rb));
        chk("dirty",    128'(gd), 128'(e.dirty));
        chk("dbg_regs", gg, e.dbg);
      end
    end
  end

  initial begin
    idle_s();
    idle_w();
    model_reset();
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;

    // Fill R0..R3, then read R1/R3.
    drive(0, 1, 0, 16'h11, 0, 0, 0, 0);
    drive(0, 1, 1, 16'h22, 0, 0, 0, 0);
    drive(0, 1, 2, 16'h33, 0, 0, 0, 0);
    drive(0, 1, 3, 16'h44, 0, 0, 0, 0);
    drive(0, 0, 0, 16'h00, 1, 1, 3, 0);
    // Same-address write/read collision, then read R2 back.
    drive(0, 1, 2, 16'hAA, 1, 2, 2, 0);
    drive(0, 0, 0, 16'h00, 1, 2, 0, 0);
    // Hold: addresses change and writes happen with rd_en low.
    drive(0, 1, 1, 16'h99, 0, 0, 1, 0);
    drive(0, 1, 3, 16'h77, 0, 3, 2, 0);
    // Clear wins over write; port A returns pre-clear R1.
    drive(0, 1, 1, 16'h5A, 1, 1, 3, 1);
    drive(0, 0, 0, 16'h00, 1, 1, 3, 0);

    for (int n = 0; n < 200; n++)
      drive(0, 1'($urandom_range(0, 1)), $urandom_range(0, 3), 16'($urandom),
            1'($urandom_range(0, 3) != 0), $urandom_range(0, 3), $urandom_range(0, 3),
            1'($urandom_range(0, 15) == 0));

    // Wide instance: R7 write and read on port B, then random traffic.
    drive(1, 1, 7, 16'hBEEF, 0, 0, 0, 0);
    drive(1, 0, 0, 16'h0000, 1, 0, 7, 0);
    for (int n = 0; n < 150; n++)
      drive(1, 1'($urandom_range(0, 1)), $urandom_range(0, 7), 16'($urandom),
            1'($urandom_range(0, 3) != 0), $urandom_range(0, 7), $urandom_range(0, 7),
            1'($urandom_range(0, 15) == 0));

    // Make sure the small file holds data and a read value before the async reset.
    drive(0, 1, 0, 16'hC3, 0, 0, 0, 0);
    drive(0, 0, 0, 16'h00, 1, 0, 0, 0);
    @(posedge clk);
    #2;
    if (q.size() != 0) chk("queue_drained", 128'(q.size()), '0);

    // Reset asserted mid-cycle while a write is pending.
    @(negedge clk);
    idle_w();
    bs.wr_n = 1'b0; bs.wa = 2'd1; bs.wd = 8'h66; bs.rd_en = 1'b1; bs.clr = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    @(posedge clk);
    #1;
    chk("rst_write_lost", 128'(bs.dbg_regs), '0);
    @(negedge clk);
    idle_s();
    rst_n = 1'b1;
    model_reset();
    drive(0, 0, 0, 16'h00, 1, 1, 2, 0);
    @(posedge clk);
    #2;
    if (q.size() != 0) chk("queue_drained_end", 128'(q.size()), '0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, errors=%0d", n_err);
    $fatal(1);
  end

endmodule
